// File: rtl/shortest_path_engine.sv
// shortest_path_engine
//   All-pairs shortest paths (Floyd-Warshall) over an N-node graph with
//   D_WIDTH-bit weights. The adjacency matrix is read from memory M, relaxed
//   in scratch memory L, and the distance and next-hop matrices are written to
//   result memory P. Every memory is a synchronous SRAM port with one cycle of
//   read latency.
//
//   Ports:
//     Clk, Rst          clock; asynchronous active-low reset
//     Go                start pulse (honoured in IDLE and DONE only)
//     M_In, L_In        read data from M and L
//     M_Addr/En/We      M port (read-only, M_We tied low)
//     L_Addr/En/We/Out  L port
//     P_Addr/En/We/Out  P port (write-only)
//     Done              high once P holds the final result
//
//   Memory layout: entry (i,j) sits at byte i*N+j. Next-hop entries sit at
//   byte N*N+i*N+j. P has no read-back path to the engine, so a mirror copy
//   of the next-hop matrix is kept in the upper half of L. Every next-hop
//   update is written to both L and P, so reads of the L mirror always match
//   P's next-hop half.
module shortest_path_engine #(
    parameter int                  N       = 64,
    parameter int                  D_WIDTH = 8,
    parameter int                  A_WIDTH = 13,
    parameter logic [D_WIDTH-1:0]  INF     = 8'hFF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Go,
    input  logic [D_WIDTH-1:0] M_In,
    input  logic [D_WIDTH-1:0] L_In,
    output logic [D_WIDTH-1:0] L_Out,
    output logic [D_WIDTH-1:0] P_Out,
    output logic [A_WIDTH-1:0] M_Addr,
    output logic [A_WIDTH-1:0] L_Addr,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic               M_En,
    output logic               M_We,
    output logic               L_En,
    output logic               L_We,
    output logic               P_En,
    output logic               P_We,
    output logic               Done
);

    localparam int                 LOG_N    = $clog2(N);
    localparam int                 AC_W     = 2 * LOG_N;
    localparam logic [A_WIDTH-1:0] HOP_BASE = A_WIDTH'(N * N);

    typedef enum logic [4:0] {
        S_IDLE, S_INIT_RD, S_INIT_WAIT, S_INIT_WR, S_INIT_HOP,
        S_R_IK, S_R_HOP, S_R_IK_C, S_R_HOP_C,
        S_R_KJ, S_R_IJ, S_R_KJ_C, S_R_CMP, S_R_HOP_WR,
        S_COPY_RD, S_COPY_WAIT, S_COPY_WR, S_DONE
    } state_t;

    state_t             state_r, state_nx;
    logic [AC_W-1:0]    a_r, a_nx;
    logic [LOG_N-1:0]   k_r, k_nx, i_r, i_nx, j_r, j_nx;
    logic [D_WIDTH-1:0] lik_r, lik_nx, hik_r, hik_nx, lkj_r, lkj_nx;
    logic [D_WIDTH-1:0] l_out_r, l_out_nx, p_out_r, p_out_nx;
    logic [A_WIDTH-1:0] m_addr_r, m_addr_nx, l_addr_r, l_addr_nx, p_addr_r, p_addr_nx;
    logic               m_en_r, m_en_nx, l_en_r, l_en_nx, l_we_r, l_we_nx;
    logic               p_en_r, p_en_nx, p_we_r, p_we_nx, done_r, done_nx;
    logic [D_WIDTH:0]   sum_s;
    logic [D_WIDTH-1:0] sat_s;
    logic               better_s;
    logic               advance_s;

    // Byte address of matrix cell (row,col); hop selects the next-hop half.
    function automatic logic [A_WIDTH-1:0] cell_addr(input logic hop,
                                                     input logic [LOG_N-1:0] row,
                                                     input logic [LOG_N-1:0] col);
        logic [A_WIDTH-1:0] base;
        base = hop ? HOP_BASE : {A_WIDTH{1'b0}};
        return base + A_WIDTH'({row, col});
    endfunction

    assign M_We   = 1'b0;
    assign M_En   = m_en_r;
    assign M_Addr = m_addr_r;
    assign L_En   = l_en_r;
    assign L_We   = l_we_r;
    assign L_Addr = l_addr_r;
    assign L_Out  = l_out_r;
    assign P_En   = p_en_r;
    assign P_We   = p_we_r;
    assign P_Addr = p_addr_r;
    assign P_Out  = p_out_r;
    assign Done   = done_r;

    // Saturating path sum through k and strict-improvement test against L[i][j].
    always_comb begin
        sum_s = {1'b0, lik_r} + {1'b0, lkj_r};
        if ((lik_r == INF) || (lkj_r == INF) || (sum_s >= {1'b0, INF})) begin
            sat_s = INF;
        end else begin
            sat_s = sum_s[D_WIDTH-1:0];
        end
        better_s = (sat_s < L_In);
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_nx  = state_r;
        a_nx      = a_r;
        k_nx      = k_r;
        i_nx      = i_r;
        j_nx      = j_r;
        lik_nx    = lik_r;
        hik_nx    = hik_r;
        lkj_nx    = lkj_r;
        l_out_nx  = l_out_r;
        p_out_nx  = p_out_r;
        m_addr_nx = m_addr_r;
        l_addr_nx = l_addr_r;
        p_addr_nx = p_addr_r;
        m_en_nx   = 1'b0;
        l_en_nx   = 1'b0;
        l_we_nx   = 1'b0;
        p_en_nx   = 1'b0;
        p_we_nx   = 1'b0;
        done_nx   = 1'b0;
        advance_s = 1'b0;

        case (state_r)
            S_IDLE, S_DONE: begin
                if (Go) begin
                    state_nx = S_INIT_RD;
                    a_nx     = {AC_W{1'b0}};
                    k_nx     = {LOG_N{1'b0}};
                    i_nx     = {LOG_N{1'b0}};
                    j_nx     = {LOG_N{1'b0}};
                end else begin
                    done_nx  = (state_r == S_DONE);
                end
            end
            S_INIT_RD: begin
                m_en_nx   = 1'b1;
                m_addr_nx = A_WIDTH'(a_r);
                state_nx  = S_INIT_WAIT;
            end
            S_INIT_WAIT: state_nx = S_INIT_WR;
            S_INIT_WR: begin
                l_en_nx   = 1'b1;
                l_we_nx   = 1'b1;
                l_addr_nx = A_WIDTH'(a_r);
                l_out_nx  = M_In;
                p_en_nx   = 1'b1;
                p_we_nx   = 1'b1;
                p_addr_nx = HOP_BASE + A_WIDTH'(a_r);
                p_out_nx  = (M_In != INF) ? D_WIDTH'(a_r[LOG_N-1:0]) : INF;
                state_nx  = S_INIT_HOP;
            end
            S_INIT_HOP: begin
                // Mirror the next-hop value just issued to P into L.
                l_en_nx   = 1'b1;
                l_we_nx   = 1'b1;
                l_addr_nx = HOP_BASE + A_WIDTH'(a_r);
                l_out_nx  = p_out_r;
                a_nx      = a_r + AC_W'(1);
                state_nx  = (&a_r) ? S_R_IK : S_INIT_RD;
            end
            S_R_IK: begin
                l_en_nx   = 1'b1;
                l_addr_nx = cell_addr(1'b0, i_r, k_r);
                state_nx  = S_R_HOP;
            end
            S_R_HOP: begin
                l_en_nx   = 1'b1;
                l_addr_nx = cell_addr(1'b1, i_r, k_r);
                state_nx  = S_R_IK_C;
            end
            S_R_IK_C: begin
                lik_nx   = L_In;
                state_nx = S_R_HOP_C;
            end
            S_R_HOP_C: begin
                hik_nx   = L_In;
                state_nx = S_R_KJ;
            end
            S_R_KJ: begin
                l_en_nx   = 1'b1;
                l_addr_nx = cell_addr(1'b0, k_r, j_r);
                state_nx  = S_R_IJ;
            end
            S_R_IJ: begin
                l_en_nx   = 1'b1;
                l_addr_nx = cell_addr(1'b0, i_r, j_r);
                state_nx  = S_R_KJ_C;
            end
            S_R_KJ_C: begin
                lkj_nx   = L_In;
                state_nx = S_R_CMP;
            end
            S_R_CMP: begin
                // L_In now holds L[i][j]; ties keep the existing entry.
                if (better_s) begin
                    l_en_nx   = 1'b1;
                    l_we_nx   = 1'b1;
                    l_addr_nx = cell_addr(1'b0, i_r, j_r);
                    l_out_nx  = sat_s;
                    p_en_nx   = 1'b1;
                    p_we_nx   = 1'b1;
                    p_addr_nx = cell_addr(1'b1, i_r, j_r);
                    p_out_nx  = hik_r;
                    state_nx  = S_R_HOP_WR;
                end else begin
                    advance_s = 1'b1;
                end
            end
            S_R_HOP_WR: begin
                l_en_nx   = 1'b1;
                l_we_nx   = 1'b1;
                l_addr_nx = cell_addr(1'b1, i_r, j_r);
                l_out_nx  = hik_r;
                advance_s = 1'b1;
            end
            S_COPY_RD: begin
                l_en_nx   = 1'b1;
                l_addr_nx = A_WIDTH'(a_r);
                state_nx  = S_COPY_WAIT;
            end
            S_COPY_WAIT: state_nx = S_COPY_WR;
            S_COPY_WR: begin
                p_en_nx   = 1'b1;
                p_we_nx   = 1'b1;
                p_addr_nx = A_WIDTH'(a_r);
                p_out_nx  = L_In;
                a_nx      = a_r + AC_W'(1);
                if (&a_r) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_COPY_RD;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Step j innermost, then i, then k; the cache reloads whenever j wraps.
        if (advance_s) begin
            j_nx = j_r + LOG_N'(1);
            if (&j_r) begin
                i_nx = i_r + LOG_N'(1);
                if ((&i_r) && (&k_r)) begin
                    k_nx     = k_r + LOG_N'(1);
                    state_nx = S_COPY_RD;
                end else if (&i_r) begin
                    k_nx     = k_r + LOG_N'(1);
                    state_nx = S_R_IK;
                end else begin
                    state_nx = S_R_IK;
                end
            end else begin
                state_nx = S_R_KJ;
            end
        end else begin
            advance_s = 1'b0;
        end
    end

    // State, datapath and registered memory-port outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r  <= S_IDLE;
            a_r      <= {AC_W{1'b0}};
            k_r      <= {LOG_N{1'b0}};
            i_r      <= {LOG_N{1'b0}};
            j_r      <= {LOG_N{1'b0}};
            lik_r    <= {D_WIDTH{1'b0}};
            hik_r    <= {D_WIDTH{1'b0}};
            lkj_r    <= {D_WIDTH{1'b0}};
            l_out_r  <= {D_WIDTH{1'b0}};
            p_out_r  <= {D_WIDTH{1'b0}};
            m_addr_r <= {A_WIDTH{1'b0}};
            l_addr_r <= {A_WIDTH{1'b0}};
            p_addr_r <= {A_WIDTH{1'b0}};
            m_en_r   <= 1'b0;
            l_en_r   <= 1'b0;
            l_we_r   <= 1'b0;
            p_en_r   <= 1'b0;
            p_we_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            a_r      <= a_nx;
            k_r      <= k_nx;
            i_r      <= i_nx;
            j_r      <= j_nx;
            lik_r    <= lik_nx;
            hik_r    <= hik_nx;
            lkj_r    <= lkj_nx;
            l_out_r  <= l_out_nx;
            p_out_r  <= p_out_nx;
            m_addr_r <= m_addr_nx;
            l_addr_r <= l_addr_nx;
            p_addr_r <= p_addr_nx;
            m_en_r   <= m_en_nx;
            l_en_r   <= l_en_nx;
            l_we_r   <= l_we_nx;
            p_en_r   <= p_en_nx;
            p_we_r   <= p_we_nx;
            done_r   <= done_nx;
        end
    end

endmodule

// File: tb/tb_shortest_path_engine.sv
// Bench for shortest_path_engine. The engine is built with an 8-node graph so
// that several complete runs stay short; all addressing follows i*N+j with the
// next-hop half starting at N*N. The bench owns the three SRAMs and acts as
// the host on their B side (loads M, inspects P).
module tb_shortest_path_engine;

    localparam int         N   = 8;
    localparam int         NN  = N * N;
    localparam int         AW  = 13;
    localparam logic [7:0] INF = 8'hFF;

    logic          clk_s;
    logic          rst_n_s;
    logic          go_s;
    logic          clr_s;
    logic [7:0]    m_in_s, l_in_s, l_out_s, p_out_s;
    logic [AW-1:0] m_addr_s, l_addr_s, p_addr_s;
    logic          m_en_s, m_we_s, l_en_s, l_we_s, p_en_s, p_we_s, done_s;

    logic [7:0] m_mem [0:8191];
    logic [7:0] l_mem [0:8191];
    logic [7:0] p_mem [0:8191];
    logic [7:0] exp_d [0:NN-1];
    logic [7:0] exp_h [0:NN-1];

    int vectors;
    int miscompares;

    shortest_path_engine #(.N(N), .D_WIDTH(8), .A_WIDTH(AW), .INF(INF)) dut (
        .Clk(clk_s), .Rst(rst_n_s), .Go(go_s),
        .M_In(m_in_s), .L_In(l_in_s), .L_Out(l_out_s), .P_Out(p_out_s),
        .M_Addr(m_addr_s), .L_Addr(l_addr_s), .P_Addr(p_addr_s),
        .M_En(m_en_s), .M_We(m_we_s), .L_En(l_en_s), .L_We(l_we_s),
        .P_En(p_en_s), .P_We(p_we_s), .Done(done_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    // Port-A side of the three SRAMs; clr_s lets the host scrub L and P.
    always @(posedge clk_s) begin
        if (clr_s) begin
            for (int a = 0; a < 8192; a++) begin
                l_mem[a] <= 8'h5A;
                p_mem[a] <= 8'hAA;
            end
        end else begin
            if (m_en_s) m_in_s <= m_mem[m_addr_s];
            if (l_en_s) begin
                if (l_we_s) l_mem[l_addr_s] <= l_out_s;
                else        l_in_s <= l_mem[l_addr_s];
            end
            if (p_en_s && p_we_s) p_mem[p_addr_s] <= p_out_s;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat_add(input logic [7:0] x, input logic [7:0] y);
        int s;
        s = int'(x) + int'(y);
        if (x == INF || y == INF || s >= 255) return INF;
        return 8'(s);
    endfunction

    // Reference result: plain sequential Floyd-Warshall on the M contents.
    task automatic build_model();
        for (int a = 0; a < NN; a++) begin
            exp_d[a] = m_mem[a];
            exp_h[a] = (m_mem[a] != INF) ? 8'(a % N) : INF;
        end
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    logic [7:0] s;
                    s = sat_add(exp_d[i*N+k], exp_d[k*N+j]);
                    if (s < exp_d[i*N+j]) begin
                        exp_d[i*N+j] = s;
                        exp_h[i*N+j] = exp_h[i*N+k];
                    end
                end
    endtask

    task automatic set_base();
        for (int a = 0; a < 8192; a++) begin
            if (a < NN) m_mem[a] = ((a / N) == (a % N)) ? 8'h00 : INF;
            else        m_mem[a] = 8'h33;
        end
    endtask

    task automatic set_dense(input int heavy);
        set_base();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j && ((i * 7 + j * 3) % 5) != 0)
                    m_mem[i*N+j] = (heavy != 0) ? 8'(((i * 13 + j * 29) % 200) + 50)
                                                : 8'(((i * 13 + j * 29) % 60) + 1);
    endtask

    task automatic pulse_go();
        @(negedge clk_s) go_s = 1'b1;
        @(negedge clk_s) go_s = 1'b0;
        chk("done_low_after_go", done_s, 1'b0);
    endtask

    task automatic start_run();
        build_model();
        @(negedge clk_s) clr_s = 1'b1;
        @(negedge clk_s) clr_s = 1'b0;
        pulse_go();
    endtask

    task automatic finish_run(input string tag);
        int n;
        n = 0;
        while (done_s !== 1'b1 && n < 20000) begin
            @(negedge clk_s);
            n++;
            chk("m_we_low", m_we_s, 1'b0);
        end
        chk({tag, " done_reached"}, done_s, 1'b1);
        // Done must hold with all ports idle; this also lets the last P write land.
        repeat (4) begin
            @(negedge clk_s);
            chk({tag, " done_hold"}, done_s, 1'b1);
            chk({tag, " ports_idle"}, {m_en_s, l_en_s, l_we_s, p_en_s, p_we_s}, 5'b0);
        end
        for (int a = 0; a < NN; a++) begin
            chk($sformatf("%s dist[%0d]", tag, a), p_mem[a], exp_d[a]);
            chk($sformatf("%s hop[%0d]", tag, a), p_mem[NN+a], exp_h[a]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n_s     = 1'b0;
        go_s        = 1'b0;
        clr_s       = 1'b0;
        set_base();
        #1;
        chk("reset_done", done_s, 1'b0);
        chk("reset_ports", {m_en_s, m_we_s, l_en_s, l_we_s, p_en_s, p_we_s}, 6'b0);
        chk("reset_addr", {m_addr_s, l_addr_s, p_addr_s}, 39'b0);
        chk("reset_data", {l_out_s, p_out_s}, 16'b0);
        repeat (3) @(negedge clk_s);
        rst_n_s = 1'b1;

        // Identity graph: only self-loops.
        start_run();
        finish_run("identity");
        chk("identity d[1][1]", p_mem[1*N+1], 8'h00);
        chk("identity d[0][1]", p_mem[1], INF);
        chk("identity h[1][1]", p_mem[NN+1*N+1], 8'd1);
        chk("identity h[0][1]", p_mem[NN+1], INF);

        // Chain 0->1->2, started from DONE.
        set_base(); m_mem[1] = 8'd3; m_mem[N+2] = 8'd4;
        start_run();
        finish_run("chain");
        chk("chain d[0][2]", p_mem[2], 8'd7);
        chk("chain h[0][2]", p_mem[NN+2], 8'd1);
        chk("chain d[0][1]", p_mem[1], 8'd3);
        chk("chain h[0][1]", p_mem[NN+1], 8'd1);

        // Tie: direct 10 versus 5+5 keeps the direct edge.
        set_base(); m_mem[2] = 8'd10; m_mem[1] = 8'd5; m_mem[N+2] = 8'd5;
        start_run();
        finish_run("tie");
        chk("tie d[0][2]", p_mem[2], 8'd10);
        chk("tie h[0][2]", p_mem[NN+2], 8'd2);

        // 0x80 + 0x80 saturates to unreachable.
        set_base(); m_mem[1] = 8'h80; m_mem[N+2] = 8'h80;
        start_run();
        finish_run("saturate");
        chk("saturate d[0][2]", p_mem[2], INF);
        chk("saturate h[0][2]", p_mem[NN+2], INF);

        // 200 + 100 saturates and does not beat the direct 254.
        set_base(); m_mem[1] = 8'd200; m_mem[N+2] = 8'd100; m_mem[2] = 8'd254;
        start_run();
        finish_run("shortcut");
        chk("shortcut d[0][2]", p_mem[2], 8'd254);
        chk("shortcut h[0][2]", p_mem[NN+2], 8'd2);

        // Dense graph; mid-run M is replaced and Go pulsed, both must be ignored.
        set_dense(0);
        start_run();
        repeat (600) @(negedge clk_s);
        set_base();
        pulse_go();
        finish_run("go_ignored");

        // Asynchronous reset with Done high.
        @(negedge clk_s);
        #2 rst_n_s = 1'b0;
        #1 chk("async_reset_done", done_s, 1'b0);
        @(negedge clk_s) rst_n_s = 1'b1;

        // Reset in the middle of relaxation, then a fresh run.
        set_dense(1);
        start_run();
        repeat (500) @(negedge clk_s);
        #2 rst_n_s = 1'b0;
        #1 chk("mid_reset_done", done_s, 1'b0);
        chk("mid_reset_ports", {m_en_s, l_en_s, l_we_s, p_en_s, p_we_s}, 5'b0);
        repeat (2) @(negedge clk_s);
        rst_n_s = 1'b1;
        @(negedge clk_s);
        chk("after_reset_idle_done", done_s, 1'b0);
        start_run();
        finish_run("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shortest_path_engine.md
Name: shortest_path_engine

Overview:
- All-pairs shortest-path engine using Floyd-Warshall on a 64-node graph with 8-bit edge weights.
- Reads the adjacency matrix from memory M and runs the algorithm in scratch memory L.
- Writes final distances and a next-hop matrix to result memory P.
- Connects to port A of three dual-port synchronous SRAMs (8192 x 8 on port A). Port B of each SRAM belongs to the host, which loads M and reads back P as 2048 x 32 words.

Parameters:
- N, 64: node count; matrix entry (i,j) is at byte address i*N+j.
- D_WIDTH, 8: weight/data width.
- A_WIDTH, 13: byte address width.
- INF, 8'hFF: "no edge / unreachable" code.

Ports:
- Clk  in  1  single clock; all memories share it.
- Rst  in  1  asynchronous reset, active-low.
- Go  in  1  start pulse, sampled in IDLE.
- M_In  in  8  M read data.
- L_In  in  8  L read data.
- L_Out  out  8  L write data.
- P_Out  out  8  P write data.
- M_Addr  out  13  M byte address.
- L_Addr  out  13  L byte address.
- P_Addr  out  13  P byte address.
- M_En  out  1  M enable.
- M_We  out  1  M write enable; always 0.
- L_En  out  1  L enable.
- L_We  out  1  L write enable.
- P_En  out  1  P enable.
- P_We  out  1  P write enable.
- Done  out  1  completion flag.

Behaviour:
- Memory model:
  - Access happens on the rising Clk edge when En=1. We=1 writes; We=0 reads.
  - Read data is valid one cycle after the address/enable edge.
  - 32-bit port-B word w holds bytes 4w..4w+3, with byte 4w in bits [7:0].
- Reset (Rst=0, async):
  - State goes to IDLE; all En/We=0, addresses/data=0, Done=0.
  - Reset during any phase aborts the run; partial memory contents are undefined.
- IDLE: wait for Go=1; Go in any other state is ignored. Done is cleared on leaving IDLE.
- INIT, for a = 0..4095 (i = a/64, j = a%64):
  - Read d = M[a].
  - Write L[a] = d.
  - Write P[4096+a] = (d != INF) ? j : INF.
  - Bytes 4096..8191 of M are ignored.
- RELAX, for k, i, j each 0..63, k outermost, j innermost:
  - Read L[i*64+k], L[k*64+j], L[i*64+j], and P[4096+i*64+k].
  - s = saturating sum of L[i*64+k] and L[k*64+j]: if either operand is INF or the 9-bit sum >= 255, s = INF.
  - If s < L[i*64+j] (strict), write L[i*64+j] = s and P[4096+i*64+j] = P[4096+i*64+k]. Otherwise no writes; ties keep the old value.
  - L[i*64+k] and P[4096+i*64+k] may be cached across the j loop. Cache must refresh when i or k changes (entries in row i, column k can change only when k is intermediate for itself, which leaves them unchanged).
  - Number of cycles per (k,i,j) is free; results must equal strict sequential Floyd-Warshall.
- COPY, for a = 0..4095: read L[a], write P[a] = L[a].
- DONE:
  - Done=1, all En/We=0.
  - Done stays high until reset or a new Go; a new Go restarts from INIT.
- Final P content:
  - Bytes 0..4095 = shortest distance matrix.
  - Bytes 4096..8191 = next-hop matrix: first node after i on the best path to j, or INF if j is unreachable.
- Diagonal entries are processed like any others; no forced zero.
- Output timing: all memory control outputs are registered.

Test Plan:
- Reset then Go with M all INF except M[i][i]=0:
  - P[i][i]=0, every other distance INF.
  - Next-hop[i][i]=i, all other next-hops INF; Done rises and holds.
- Edges 0->1=3, 1->2=4, rest INF, diagonal 0:
  - P[0*64+2]=7; P[4096+2]=1.
  - P[0*64+1]=3; P[4096+1]=1.
- Triangle 0->2=10, 0->1=5, 1->2=5 (tie at 10): distance stays 10, next-hop[0][2] stays 2 (strict <).
- Saturation, 0->1=0x80, 1->2=0x80, 0->2=INF: distance[0][2]=INF, next-hop[0][2]=INF.
- Shortcut, 0->1=200, 1->2=100, 0->2=254: sum 300 saturates to INF, so distance[0][2] stays 254.
- Assert Rst=0 mid-RELAX, release, pulse Go:
  - Done is 0 immediately after reset.
  - The fresh run produces the correct full 8192-byte P.
  - Go pulsed during RELAX is ignored.
